// File: rtl/mdclcg_enc_pkg.sv
// mdclcg_enc_pkg: shared sizing helper, default widths and priority-direction encodings.
package mdclcg_enc_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_GROUP = 8;
  localparam int PRIO_LSB = 0;
  localparam int PRIO_MSB = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/enc_group.sv
// enc_group: combinational N-to-log2(N) priority encoder with hit flag; index 0 when nothing is set.
module enc_group
  import mdclcg_enc_pkg::*;
#(
  parameter int N        = DEF_GROUP,
  parameter int MSB_PRIO = PRIO_LSB
) (
  input  logic [N-1:0]          vec_i,
  output logic [clog2(N)-1:0]   idx_o,
  output logic                  hit_o
);
  localparam int IW = clog2(N);
  // Scan from the losing end so the last match written is the winner.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++)
      if (vec_i[MSB_PRIO == PRIO_MSB ? i : N-1-i]) idx_o = IW'(MSB_PRIO == PRIO_MSB ? i : N-1-i);
  end
  assign hit_o = |vec_i;
endmodule

// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: two-stage pipelined priority encoder with valid/ready flow control.
// Define PRIO_ENC_MULTIHOT_EN to add the registered out_multi (two or more bits set) output.
module prio_enc_pipe
  import mdclcg_enc_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int GROUP    = DEF_GROUP,
  parameter int MSB_PRIO = PRIO_LSB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [clog2(WIDTH)-1:0]  out,
  output logic                     out_hit,
  output logic                     out_valid,
`ifdef PRIO_ENC_MULTIHOT_EN
  output logic                     out_multi,
`endif
  input  logic                     out_ready
);
  localparam int NG   = WIDTH / GROUP;
  localparam int LW   = clog2(GROUP);
  localparam int GW   = clog2(NG);
  localparam int IDXW = clog2(WIDTH);
  logic [NG-1:0]          grp_hit, s1_hit_q, s1_hit_d;
  logic [NG-1:0][LW-1:0]  grp_idx, s1_idx_q, s1_idx_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [GW-1:0]          win_grp;
  logic                   any_hit;
  logic [IDXW-1:0]        out_q, out_d;
  logic                   out_hit_q, out_hit_d, out_valid_q, out_valid_d;
  logic                   s2_adv, s2_load;
  genvar g;
  for (g = 0; g < NG; g++) begin : g_grp
    enc_group #(.N(GROUP), .MSB_PRIO(MSB_PRIO)) u_enc (
      .vec_i(in[g*GROUP +: GROUP]),
      .idx_o(grp_idx[g]),
      .hit_o(grp_hit[g])
    );
  end
  enc_group #(.N(NG), .MSB_PRIO(MSB_PRIO)) u_top (
    .vec_i(s1_hit_q),
    .idx_o(win_grp),
    .hit_o(any_hit)
  );
  assign s2_adv   = !out_valid_q | out_ready;
  assign s2_load  = s2_adv & s1_valid_q;
  assign in_ready = !s1_valid_q | s2_adv;
  always_comb begin
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_hit_d    = in_ready ? grp_hit : s1_hit_q;
    s1_idx_d    = in_ready ? grp_idx : s1_idx_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_d       = s2_load ? {win_grp, s1_idx_q[win_grp]} : out_q;
    out_hit_d   = s2_load ? any_hit : out_hit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_hit_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_idx_q    <= s1_idx_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_hit_q   <= out_hit_d;
    end
  end
  assign out       = out_q;
  assign out_hit   = out_hit_q;
  assign out_valid = out_valid_q;
`ifdef PRIO_ENC_MULTIHOT_EN
  // Multi-hot means a group holds two bits, or two groups are hit.
  logic [NG-1:0] grp_multi, s1_multi_q, s1_multi_d;
  logic          out_multi_q, out_multi_d;
  for (g = 0; g < NG; g++) begin : g_multi
    assign grp_multi[g] = |(in[g*GROUP +: GROUP] & (in[g*GROUP +: GROUP] - GROUP'(1)));
  end
  always_comb begin
    s1_multi_d  = in_ready ? grp_multi : s1_multi_q;
    out_multi_d = s2_load ? (|s1_multi_q | |(s1_hit_q & (s1_hit_q - NG'(1)))) : out_multi_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_multi_q  <= '0;
      out_multi_q <= 1'b0;
    end else begin
      s1_multi_q  <= s1_multi_d;
      out_multi_q <= out_multi_d;
    end
  end
  assign out_multi = out_multi_q;
`endif
endmodule

// File: tb/tb_prio_enc_pipe.sv
// tb_prio_enc_pipe: randomized and directed checks of LSB- and MSB-priority instances against a queue model.
module tb_prio_enc_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_vec = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        rdy_l, rdy_m, ov_l, ov_m, hit_l, hit_m, mu_l, mu_m;
  logic [5:0]  o_l, o_m;
  int          checks = 0, failures = 0, rcv = 0;
  logic        acc;
  logic [63:0] ql[$], qm[$];
  always #5 clk = ~clk;
  prio_enc_pipe #(.WIDTH(64), .GROUP(8), .MSB_PRIO(0)) dut_l (
    .clk(clk), .rst(rst), .in(in_vec), .in_valid(in_valid), .in_ready(rdy_l),
    .out(o_l), .out_hit(hit_l), .out_valid(ov_l),
`ifdef PRIO_ENC_MULTIHOT_EN
    .out_multi(mu_l),
`endif
    .out_ready(out_ready)
  );
  prio_enc_pipe #(.WIDTH(64), .GROUP(8), .MSB_PRIO(1)) dut_m (
    .clk(clk), .rst(rst), .in(in_vec), .in_valid(in_valid), .in_ready(rdy_m),
    .out(o_m), .out_hit(hit_m), .out_valid(ov_m),
`ifdef PRIO_ENC_MULTIHOT_EN
    .out_multi(mu_m),
`endif
    .out_ready(out_ready)
  );
`ifndef PRIO_ENC_MULTIHOT_EN
  assign mu_l = 1'b0;
  assign mu_m = 1'b0;
`endif
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Lowest set bit is the index of the isolated low bit; highest is floor(log2).
  function automatic int ref_idx(input logic [63:0] h, input bit msb);
    if (h == 0) return 0;
    if (!msb) return $clog2(h & (~h + 64'd1));
    return $clog2(h) - (((h & (h - 64'd1)) != 0) ? 1 : 0);
  endfunction
  task automatic chk_dut(input bit d, input logic rdy, ov, input logic [5:0] o,
                         input logic hit, mu, vv, ordy, input logic [63:0] v);
    int n;
    logic [63:0] h;
    string p;
    p = d ? "m" : "l";
    n = d ? qm.size() : ql.size();
    check({p, "_in_ready"}, rdy, !(n == 2 && !ordy));
    if (n == 2) check({p, "_full_valid"}, ov, 1);
    if (n == 0) check({p, "_idle_valid"}, ov, 0);
    if (ov && ordy && n > 0) begin
      h = d ? qm.pop_front() : ql.pop_front();
      if (!d) rcv++;
      check({p, "_out"}, o, ref_idx(h, d));
      check({p, "_hit"}, hit, h != 0);
`ifdef PRIO_ENC_MULTIHOT_EN
      check({p, "_multi"}, mu, $countones(h) >= 2);
`endif
    end
    if (vv && rdy) begin
      if (d) qm.push_back(v);
      else ql.push_back(v);
    end
  endtask
  task automatic step(input logic [63:0] v, input logic vv, ordy, r);
    @(negedge clk);
    in_vec = v; in_valid = vv; out_ready = ordy; rst = r;
    #1;
    acc = 1'b0;
    if (r) begin
      ql.delete();
      qm.delete();
    end else begin
      acc = vv && rdy_l;
      chk_dut(0, rdy_l, ov_l, o_l, hit_l, mu_l, vv, ordy, v);
      chk_dut(1, rdy_m, ov_m, o_m, hit_m, mu_m, vv, ordy, v);
    end
  endtask
  initial begin
    logic [3:0]  pat;
    logic [63:0] v;
    int k, cyc, r0;
    pat = 4'b1001;
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    check("rst_out", o_l, 0);
    check("rst_hit", hit_l, 0);
    check("rst_ready", rdy_l, 1);
    step(64'h0000_0100_0000_0010, 1, 1, 0);
    step(0, 0, 1, 0);
    check("lat_early", ov_l, 0);
    step(0, 0, 1, 0);
    check("lat_valid", ov_l, 1);
    check("lsb_out", o_l, 4);
    check("msb_out", o_m, 40);
    check("msb_hit", hit_m, 1);
`ifdef PRIO_ENC_MULTIHOT_EN
    check("two_multi", mu_m, 1);
`endif
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("zero_valid", ov_l, 1);
    check("zero_out", o_m, 0);
    check("zero_hit", hit_l, 0);
    step(64'h8000_0000_0000_0000, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("top_out_l", o_l, 63);
    check("top_out_m", o_m, 63);
    check("top_multi", mu_l, 0);
    k = 0; cyc = 0; r0 = rcv;
    while (k < 64 && cyc < 1000) begin
      v = 64'd1 << k;
      step(v, 1, pat[cyc % 4], 0);
      if (acc) k++;
      cyc++;
    end
    check("seq_sent", k, 64);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    check("seq_recv", rcv - r0, 64);
    step(64'h0f, 1, 0, 0);
    step(64'hf0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    check("mid_rst_valid", ov_l, 0);
    check("mid_rst_out", o_l, 0);
    check("mid_rst_ready", rdy_l, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 4)
        0: v = '0;
        1: v = 64'd1 << $urandom_range(63);
        2: v = (64'd1 << $urandom_range(63)) | (64'd1 << $urandom_range(63));
        default: v = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      step(v, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 300) == 0);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    check("drain_l", ql.size(), 0);
    check("drain_m", qm.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
